// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM/IO bus owner serving icache line fills and load/store accesses
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable, low freezes all state and blocks writes
//   if_en/if_pc         fetch line request and line base address
//   if_done/if_data     one-cycle completion pulse and assembled line (byte k at [8k+7:8k])
//   lsb_en/lsb_wr       load/store request, 1 = store
//   lsb_len/lsb_addr    access size (00 byte, 01 half, 10 word) and byte address
//   lsb_wdata           store data, little-endian
//   lsb_done/lsb_rdata  one-cycle completion pulse and zero-extended load data
//   mem_din/mem_dout    RAM read byte / write byte
//   mem_a/mem_wr        RAM byte address / write strobe
//   io_buffer_full      IO output buffer full, stalls IO-mapped write bytes
module mem_ctrl #(
    parameter int         IF_LINE_BYTES = 64,
    parameter logic [1:0] IO_SEL        = 2'b11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       if_en,
    input  logic [31:0]                if_pc,
    output logic                       if_done,
    output logic [8*IF_LINE_BYTES-1:0] if_data,
    input  logic                       lsb_en,
    input  logic                       lsb_wr,
    input  logic [1:0]                 lsb_len,
    input  logic [31:0]                lsb_addr,
    input  logic [31:0]                lsb_wdata,
    output logic                       lsb_done,
    output logic [31:0]                lsb_rdata,
    input  logic [7:0]                 mem_din,
    output logic [7:0]                 mem_dout,
    output logic [31:0]                mem_a,
    output logic                       mem_wr,
    input  logic                       io_buffer_full
);
    localparam int CW = $clog2(IF_LINE_BYTES + 1);

    typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, n, lane, ls_n;
    logic [31:0]   wbuf;
    logic          take_ls, take_if, abort, rd, stall, issue, last;

    // Store data shifts down one byte per issued write, so the bus byte is always the low lane.
    assign mem_dout = wbuf[7:0];
    assign stall    = mem_a[17:16] == IO_SEL && io_buffer_full;
    assign mem_wr   = rdy && state == LS_WRITE && !stall;

    always_comb begin
        take_ls = state == IDLE && lsb_en && !lsb_done;
        take_if = state == IDLE && !take_ls && if_en && !if_done;
        abort   = state == IF_READ && !if_en;
        rd      = state == LS_READ || (state == IF_READ && if_en);
        issue   = state == LS_WRITE && !stall;
        // Reads finish one cycle after the last address (RAM latency); writes on the last issue.
        last    = state == LS_WRITE ? issue && cnt == n - CW'(1) : cnt == n;
        lane    = cnt - CW'(1);
        ls_n    = lsb_len == 2'b00 ? CW'(1) : lsb_len == 2'b01 ? CW'(2) : CW'(4);
        nxt     = state;
        if (take_ls)
            nxt = lsb_wr ? LS_WRITE : LS_READ;
        else if (take_if)
            nxt = IF_READ;
        else if (abort || (state != IDLE && last))
            nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= nxt;
    end

    // In a read, cnt is the index of the address on the bus; mem_din carries byte cnt-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            n         <= '0;
            mem_a     <= '0;
            wbuf      <= '0;
            if_data   <= '0;
            lsb_rdata <= '0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            if (take_ls || take_if) begin
                cnt   <= '0;
                n     <= take_ls ? ls_n : CW'(IF_LINE_BYTES);
                mem_a <= take_ls ? lsb_addr : if_pc;
                if (take_ls)
                    wbuf <= lsb_wdata;
            end else if (rd) begin
                cnt <= cnt + CW'(1);
                if (cnt + CW'(1) < n)
                    mem_a <= mem_a + 32'd1;
                if (cnt != '0 && state == IF_READ)
                    if_data[{lane, 3'b000} +: 8] <= mem_din;
                // Lane 0 write clears the upper lanes so short loads come out zero-extended.
                if (cnt == CW'(1) && state == LS_READ)
                    lsb_rdata <= {24'b0, mem_din};
                else if (cnt != '0 && state == LS_READ)
                    lsb_rdata[{lane[1:0], 3'b000} +: 8] <= mem_din;
                if (last) begin
                    if_done  <= state == IF_READ;
                    lsb_done <= state == LS_READ;
                end
            end else if (issue) begin
                cnt  <= cnt + CW'(1);
                wbuf <= wbuf >> 8;
                if (!last)
                    mem_a <= mem_a + 32'd1;
                lsb_done <= last;
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector and sequence checks of mem_ctrl against a 4 KB RAM model
module tb_mem_ctrl;
    logic         clk = 1'b0;
    logic         rst, rdy, if_en, lsb_en, lsb_wr, io_buffer_full, init_ram;
    logic [31:0]  if_pc, lsb_addr, lsb_wdata, lsb_rdata, mem_a;
    logic [1:0]   lsb_len;
    logic [511:0] if_data, want_line;
    logic         if_done, lsb_done, mem_wr;
    logic [7:0]   mem_din, mem_dout;
    logic [7:0]   ram [0:4095];
    int           n_cmp = 0, n_bad = 0, cyc = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          done_cyc;
    } vec_t;

    vec_t vecs [9];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM aliased on mem_a[11:0]; preloaded with ram[i] = i[7:0] plus a few patterns.
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 4096; i++)
                ram[i] <= 8'(i);
            ram[12'h100] <= 8'hEF;
            ram[12'h101] <= 8'hBE;
            ram[12'h102] <= 8'hAD;
            ram[12'h103] <= 8'hDE;
            ram[12'h204] <= 8'h55;
            ram[12'hFFE] <= 8'h11;
            ram[12'hFFF] <= 8'h22;
        end else if (mem_wr)
            ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int nbytes(input logic [1:0] l);
        return l == 2'b00 ? 1 : l == 2'b01 ? 2 : 4;
    endfunction

    task automatic run_ls(input vec_t v);
        int nb, done_at;
        logic ok;
        nb = nbytes(v.len);
        done_at = -1;
        ok = 1'b1;
        lsb_en = 1'b1;
        lsb_wr = v.wr;
        lsb_len = v.len;
        lsb_addr = v.addr;
        lsb_wdata = v.wdata;
        cyc = 0;
        while (done_at < 0 && cyc < 40) begin
            tick;
            if (cyc >= 1 && cyc <= nb) begin
                if (mem_a !== v.addr + 32'(cyc) - 32'd1) ok = 1'b0;
                if (mem_wr !== v.wr) ok = 1'b0;
                if (v.wr && mem_dout !== v.wdata[8*(cyc-1) +: 8]) ok = 1'b0;
            end else if (mem_wr !== 1'b0)
                ok = 1'b0;
            if (lsb_done) begin
                done_at = cyc;
                lsb_en = 1'b0;
            end
        end
        lsb_en = 1'b0;
        check("ls_done_cycle", 512'(done_at), 512'(v.done_cyc));
        check("ls_bus_sequence", 512'(ok), 512'd1);
        if (!v.wr)
            check("ls_rdata", 512'(lsb_rdata), 512'(v.rdata));
        tick;
        check("ls_done_one_cycle", 512'(lsb_done), 512'd0);
        if (v.wr)
            for (int i = 0; i < nb; i++)
                check("ls_ram_written", 512'(ram[12'(v.addr + 32'(i))]), 512'(v.wdata[8*i +: 8]));
    endtask

    // Single byte store stalled for cycles 1..k by either io_buffer_full or rdy low.
    task automatic stalled_store(input logic [31:0] addr, input logic [7:0] d, input logic use_io, input int k);
        int first_wr, nwr, done_at;
        first_wr = -1;
        nwr = 0;
        done_at = -1;
        lsb_en = 1'b1;
        lsb_wr = 1'b1;
        lsb_len = 2'b00;
        lsb_addr = addr;
        lsb_wdata = {24'h0, d};
        cyc = 0;
        while (cyc < 20) begin
            tick;
            io_buffer_full = use_io && cyc <= k;
            rdy = !(!use_io && cyc <= k);
            #1;
            if (mem_wr) begin
                nwr++;
                if (first_wr < 0) begin
                    first_wr = cyc;
                    check("stall_wr_addr", 512'(mem_a), 512'(addr));
                end
            end
            if (lsb_done && done_at < 0) begin
                done_at = cyc;
                lsb_en = 1'b0;
            end
        end
        check("stall_first_wr", 512'(first_wr), 512'(k + 1));
        check("stall_wr_count", 512'(nwr), 512'd1);
        check("stall_done_cycle", 512'(done_at), 512'(k + 2));
        check("stall_ram", 512'(ram[addr[11:0]]), 512'(d));
    endtask

    initial begin
        int done_at, ndone;
        logic ok;
        vecs[0] = '{1'b0, 2'b10, 32'h100,      32'h0,        32'hDEADBEEF, 6};
        vecs[1] = '{1'b0, 2'b00, 32'h101,      32'h0,        32'h000000BE, 3};
        vecs[2] = '{1'b0, 2'b01, 32'h102,      32'h0,        32'h0000DEAD, 4};
        vecs[3] = '{1'b1, 2'b01, 32'h202,      32'h1234ABCD, 32'h0,        3};
        vecs[4] = '{1'b1, 2'b10, 32'h300,      32'hCAFEF00D, 32'h0,        5};
        vecs[5] = '{1'b0, 2'b10, 32'h300,      32'h0,        32'hCAFEF00D, 6};
        vecs[6] = '{1'b0, 2'b01, 32'h3F,       32'h0,        32'h0000403F, 4};
        vecs[7] = '{1'b0, 2'b10, 32'hFFFFFFFE, 32'h0,        32'h01002211, 6};
        vecs[8] = '{1'b0, 2'b00, 32'h100,      32'h0,        32'h000000EF, 3};

        rst = 1'b1; init_ram = 1'b1; rdy = 1'b1; if_en = 1'b0; lsb_en = 1'b0; lsb_wr = 1'b0;
        io_buffer_full = 1'b0; if_pc = '0; lsb_addr = '0; lsb_wdata = '0; lsb_len = '0;
        tick;
        tick;
        rst = 1'b0;
        init_ram = 1'b0;
        check("reset_if_done", 512'(if_done), 512'd0);
        check("reset_lsb_done", 512'(lsb_done), 512'd0);
        check("reset_mem_wr", 512'(mem_wr), 512'd0);
        check("reset_mem_a", 512'(mem_a), 512'd0);
        check("reset_mem_dout", 512'(mem_dout), 512'd0);
        check("reset_if_data", if_data, 512'd0);
        check("reset_lsb_rdata", 512'(lsb_rdata), 512'd0);

        for (int i = 0; i < 9; i++)
            run_ls(vecs[i]);
        check("half_store_neighbour", 512'(ram[12'h204]), 512'h55);

        // Line fill from 0x40.
        if_en = 1'b1; if_pc = 32'h40; cyc = 0; ok = 1'b1; done_at = -1; ndone = 0;
        while (cyc < 70) begin
            tick;
            if (cyc >= 1 && cyc <= 64 && mem_a !== 32'h40 + 32'(cyc) - 32'd1) ok = 1'b0;
            if (mem_wr) ok = 1'b0;
            if (if_done) begin
                if (done_at < 0) done_at = cyc;
                ndone++;
                if_en = 1'b0;
            end
        end
        for (int k = 0; k < 64; k++)
            want_line[8*k +: 8] = 8'(8'h40 + k);
        check("fetch_addr_walk", 512'(ok), 512'd1);
        check("fetch_done_cycle", 512'(done_at), 512'd66);
        check("fetch_done_count", 512'(ndone), 512'd1);
        check("fetch_line", if_data, want_line);
        check("fetch_byte0", 512'(if_data[7:0]), 512'h40);
        check("fetch_byte63", 512'(if_data[511:504]), 512'h7F);

        // Both requesters at once: the word load wins, the fetch follows its done cycle.
        begin
            int ls_at, if_at;
            logic [31:0] a1, a7;
            ls_at = -1; if_at = -1; a1 = '0; a7 = '0;
            lsb_en = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b10; lsb_addr = 32'h100;
            if_en = 1'b1; if_pc = 32'h80; cyc = 0;
            while (cyc < 80) begin
                tick;
                if (cyc == 1) a1 = mem_a;
                if (cyc == 7) a7 = mem_a;
                if (lsb_done && ls_at < 0) begin ls_at = cyc; lsb_en = 1'b0; end
                if (if_done && if_at < 0) begin if_at = cyc; if_en = 1'b0; end
            end
            check("arb_load_first_addr", 512'(a1), 512'h100);
            check("arb_load_done", 512'(ls_at), 512'd6);
            check("arb_load_rdata", 512'(lsb_rdata), 512'hDEADBEEF);
            check("arb_fetch_addr", 512'(a7), 512'h80);
            check("arb_fetch_done", 512'(if_at), 512'd72);
            check("arb_fetch_byte0", 512'(if_data[7:0]), 512'h80);
        end

        // Fetch withdrawn at cycle 10, redirected to 0x80 at cycle 11.
        begin
            logic [31:0] a12;
            a12 = '0; done_at = -1; ndone = 0;
            if_en = 1'b1; if_pc = 32'h40; cyc = 0;
            while (cyc < 82) begin
                tick;
                if (cyc == 10) if_en = 1'b0;
                if (cyc == 11) begin if_en = 1'b1; if_pc = 32'h80; end
                if (cyc == 12) a12 = mem_a;
                if (if_done) begin
                    if (done_at < 0) done_at = cyc;
                    ndone++;
                    if_en = 1'b0;
                end
            end
            check("abort_new_addr", 512'(a12), 512'h80);
            check("abort_done_cycle", 512'(done_at), 512'd77);
            check("abort_done_count", 512'(ndone), 512'd1);
            check("abort_byte1", 512'(if_data[15:8]), 512'h81);
        end

        stalled_store(32'h30000, 8'hA5, 1'b1, 4);
        stalled_store(32'h500, 8'h5A, 1'b0, 2);
        rdy = 1'b1;
        io_buffer_full = 1'b0;

        // Reset during cycle 2 of a word store.
        begin
            int nd, nw;
            nd = 0; nw = 0;
            lsb_en = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b10; lsb_addr = 32'h400; lsb_wdata = 32'h11223344;
            cyc = 0;
            tick;
            tick;
            rst = 1'b1;
            lsb_en = 1'b0;
            tick;
            rst = 1'b0;
            check("rst_mid_mem_wr", 512'(mem_wr), 512'd0);
            check("rst_mid_mem_a", 512'(mem_a), 512'd0);
            check("rst_mid_lsb_done", 512'(lsb_done), 512'd0);
            repeat (8) begin
                tick;
                if (lsb_done) nd++;
                if (mem_wr) nw++;
            end
            check("rst_mid_no_done", 512'(nd), 512'd0);
            check("rst_mid_no_wr", 512'(nw), 512'd0);
            check("rst_mid_byte0", 512'(ram[12'h400]), 512'h44);
            check("rst_mid_byte2", 512'(ram[12'h402]), 512'h02);
            run_ls('{1'b0, 2'b00, 32'h400, 32'h0, 32'h44, 3});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sole owner of the byte-wide RAM/IO bus.
- Responder for two initiators:
  - instruction fetch: 64-byte line fills for the icache.
  - load/store buffer: byte, half or word accesses.
- Arbitrates between them, sequences one byte per cycle over the RAM port, and assembles line and load data little-endian.
- Honours the IO write back-pressure signal.

Parameters:
- IF_LINE_BYTES, 64, bytes per icache line fill; if_data width = 8*IF_LINE_BYTES.
- IO_SEL, 2'b11, value of addr[17:16] that marks an IO-mapped address.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- if_en  in  1  fetch line request; held high until if_done or withdrawn
- if_pc  in  32  line base address, [5:0]=0
- if_done  out  1  one-cycle pulse, line complete
- if_data  out  512  line bytes, byte k at [8k+7:8k]
- lsb_en  in  1  load/store request; held until lsb_done
- lsb_wr  in  1  1=store, 0=load
- lsb_len  in  2  00 byte, 01 half, 10 word
- lsb_addr  in  32  access address
- lsb_wdata  in  32  store data, little-endian
- lsb_done  out  1  one-cycle pulse, access complete
- lsb_rdata  out  32  load data, zero-extended (sign extension done by LSB)
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1=write
- io_buffer_full  in  1  IO output buffer full

Behaviour:
- Reset (rst high at an edge, including mid-transfer):
  - state IDLE; if_done=0, lsb_done=0, mem_wr=0, mem_a=0, mem_dout=0, if_data=0, lsb_rdata=0.
  - Any partial transfer is discarded.
- rdy low: no register changes; mem_wr gated to 0 combinationally.
- States: IDLE, IF_READ, LS_READ, LS_WRITE.
- IDLE acceptance:
  - lsb_en has priority over if_en when both are high.
  - Accept only if the corresponding done output is low this cycle, so a request is never re-accepted on its own done cycle.
  - Latch base address, byte count N (1/2/4, or IF_LINE_BYTES) and store data.
  - Reset byte counters.
- Read timing (accept edge = cycle 0):
  - mem_a = base+k during cycle k+1, for k = 0..N-1.
  - RAM returns that byte on mem_din in cycle k+2; it is captured into byte lane k at the end of that cycle.
  - Done pulse and final data are valid in cycle N+2.
  - Fetch line done = cycle 66; word load done = cycle 6; byte load done = cycle 3.
- Write timing: mem_wr=1, mem_a=base+k, mem_dout=wdata byte k in cycle k+1; lsb_done in cycle N+1.
- IO stall:
  - While a pending write byte has mem_a[17:16]==IO_SEL and io_buffer_full=1, that byte is not issued (mem_wr=0) and its counter does not advance.
  - Issue resumes in the first cycle with io_buffer_full=0.
- Fetch withdrawal: if if_en is low in any IF_READ cycle (pc redirect), abort.
  - IDLE next cycle, no if_done, if_data undefined-but-stable.
  - A new if_en may be accepted from IDLE the following edge.
- Load/store requests are never aborted.
- Done pulses last exactly one cycle.
- Data outputs hold their value until the next transfer of the same port starts overwriting lanes.
- Back to IDLE on the done cycle.
- Idle bus: mem_wr=0, mem_a unchanged.
- Address arithmetic: 32-bit wrap, no alignment check.
- Half/word accesses may cross lines.

Test Plan:
- Fetch fill: RAM[0x40..0x7F]=0x40..0x7F; if_en=1, if_pc=0x40 → mem_a walks 0x40..0x7F in cycles 1..64; if_done in cycle 66 only; if_data[7:0]=0x40, if_data[511:504]=0x7F.
- Word load: RAM[0x100..0x103]=EF,BE,AD,DE; lsb_en, lsb_wr=0, len=10, addr=0x100 → lsb_done cycle 6, lsb_rdata=0xDEADBEEF.
- Half store: lsb_wr=1, len=01, addr=0x202, wdata=0x1234ABCD → mem_wr cycles 1–2 with (0x202,CD),(0x203,AB); lsb_done cycle 3; RAM[0x204] untouched.
- IO stall: byte store to 0x30000, io_buffer_full high cycles 1–4 → no mem_wr until cycle 5; lsb_done cycle 6.
- Arbitration/abort:
  - if_en and lsb_en both high in IDLE → load served first, fetch starts after lsb_done.
  - Dropping if_en at fetch cycle 10 → no if_done; new if_pc=0x80 accepted, mem_a=0x80 two cycles later.
- Reset mid-store (rst at cycle 2 of word store) → mem_wr=0 next cycle, no lsb_done, state IDLE.
